// File: rtl/bist_march_ctrl.sv
// March C- BIST sequencer: drives an external up/down address generator and
// a memory, checks read data against the background, and reports pass/fail
// with the first failing address and March element.
// Optional build macro: BIST_STOP_ON_FAIL_EN (end the test at the first mismatch).
module bist_march_ctrl #(
  parameter int ADR_SIZE = 4,
  parameter int DATA_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                cnt_rst,
  output logic                cnt_preset,
  output logic                cnt_en,
  output logic                cnt_up_down,
  input  logic [ADR_SIZE-1:0] cnt_adr,
  input  logic                cnt_cout,
  output logic                mem_we,
  output logic                mem_re,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic [ADR_SIZE-1:0] fail_adr,
  output logic [2:0]          fail_elem
);

  typedef enum logic [2:0] {IDLE, INIT, WR, RD, CMP, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  elem, elem_nxt;
  logic        elem_up;
  logic        launch;
  logic        mismatch;
  logic [DATA_W-1:0] exp_bg, wr_bg;

  // Elements 3 and 4 walk downward; all others walk upward.
  assign elem_up  = (elem != 3'd3) && (elem != 3'd4);
  // Odd elements read 0 and write 1; even elements read 1 and write 0.
  assign exp_bg   = elem[0] ? '0 : '1;
  assign wr_bg    = elem[0] ? '1 : '0;
  assign launch   = ((state == IDLE) || (state == DONE)) && start;
  assign mismatch = (state == CMP) && (mem_rdata != exp_bg);

  // State and element registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      elem  <= '0;
    end else begin
      state <= state_nxt;
      elem  <= elem_nxt;
    end
  end

  // Result registers: cleared on launch, first mismatch captured, fail sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail      <= 1'b0;
      fail_adr  <= '0;
      fail_elem <= '0;
    end else if (launch) begin
      fail      <= 1'b0;
      fail_adr  <= '0;
      fail_elem <= '0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (!fail) begin
        fail_adr  <= cnt_adr;
        fail_elem <= elem;
      end
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt   = state;
    elem_nxt    = elem;
    cnt_rst     = 1'b0;
    cnt_preset  = 1'b0;
    cnt_en      = 1'b0;
    cnt_up_down = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_wdata   = '0;
    busy        = 1'b0;
    done        = 1'b0;
    pass        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = INIT;
          elem_nxt  = '0;
        end
      end
      INIT: begin
        busy        = 1'b1;
        cnt_up_down = elem_up;
        cnt_rst     = elem_up;
        cnt_preset  = !elem_up;
        state_nxt   = (elem == 3'd0) ? WR : RD;
      end
      WR: begin
        busy        = 1'b1;
        cnt_up_down = elem_up;
        mem_we      = 1'b1;
        if (cnt_cout) begin
          elem_nxt  = elem + 3'd1;
          state_nxt = INIT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      RD: begin
        busy        = 1'b1;
        cnt_up_down = elem_up;
        mem_re      = 1'b1;
        state_nxt   = CMP;
      end
      CMP: begin
        busy        = 1'b1;
        cnt_up_down = elem_up;
        // The final element is read-only.
        if (elem != 3'd5) begin
          mem_we    = 1'b1;
          mem_wdata = wr_bg;
        end
`ifdef BIST_STOP_ON_FAIL_EN
        if (mismatch) begin
          state_nxt = DONE;
        end else
`endif
        if (cnt_cout) begin
          elem_nxt  = elem + 3'd1;
          state_nxt = (elem == 3'd5) ? DONE : INIT;
        end else begin
          cnt_en    = 1'b1;
          state_nxt = RD;
        end
      end
      DONE: begin
        done = 1'b1;
        pass = !fail;
        if (start) begin
          state_nxt = INIT;
          elem_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
